// File: rtl/id_pkg.sv
`default_nettype none
// ============================================================================
// Module   : id_pkg
// Purpose  : Shared encodings, decode-result struct and helpers for id_stage.
// Revision : 1.0 - initial release
// ============================================================================
package id_pkg;

    localparam int ALUOP_W  = 4;
    localparam int ALUSEL_W = 2;

    localparam logic [6:0] c_OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] c_OPC_OP     = 7'b0110011;
    localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;

    localparam logic [2:0] c_F3_ADD  = 3'b000;
    localparam logic [2:0] c_F3_SLL  = 3'b001;
    localparam logic [2:0] c_F3_SLT  = 3'b010;
    localparam logic [2:0] c_F3_SLTU = 3'b011;
    localparam logic [2:0] c_F3_XOR  = 3'b100;
    localparam logic [2:0] c_F3_SR   = 3'b101;
    localparam logic [2:0] c_F3_OR   = 3'b110;
    localparam logic [2:0] c_F3_AND  = 3'b111;

    typedef enum logic [ALUOP_W-1:0] {
        ALU_NOP  = 4'd0,
        ALU_ADD  = 4'd1,
        ALU_SUB  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_OR   = 4'd6,
        ALU_AND  = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9,
        ALU_SRA  = 4'd10
    } aluop_e;

    typedef enum logic [ALUSEL_W-1:0] {
        SEL_NOP   = 2'd0,
        SEL_LOGIC = 2'd1,
        SEL_SHIFT = 2'd2,
        SEL_MATH  = 2'd3
    } alusel_e;

    typedef enum logic [1:0] {
        OP1_ZERO = 2'd0,
        OP1_PC   = 2'd1,
        OP1_RS1  = 2'd2
    } op1_sel_e;

    typedef struct packed {
        aluop_e      aluop;
        alusel_e     alusel;
        op1_sel_e    op1_sel;
        logic        use_rs2;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  wd;
        logic        wreg;
        logic        illegal;
    } dec_t;

    // Base operation implied by funct3 alone; SUB/SRA are applied by the decoder.
    function automatic aluop_e f_f3_aluop(input logic [2:0] f3);
        case (f3)
            c_F3_ADD:  return ALU_ADD;
            c_F3_SLL:  return ALU_SLL;
            c_F3_SLT:  return ALU_SLT;
            c_F3_SLTU: return ALU_SLTU;
            c_F3_XOR:  return ALU_XOR;
            c_F3_SR:   return ALU_SRL;
            c_F3_OR:   return ALU_OR;
            default:   return ALU_AND;
        endcase
    endfunction

    function automatic alusel_e f_alusel(input aluop_e op);
        case (op)
            ALU_NOP:                   return SEL_NOP;
            ALU_XOR, ALU_OR, ALU_AND:  return SEL_LOGIC;
            ALU_SLL, ALU_SRL, ALU_SRA: return SEL_SHIFT;
            default:                   return SEL_MATH;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/id_decoder.sv
`default_nettype none
// ============================================================================
// Module   : id_decoder
// Purpose  : Combinational RV32I decoder for OP-IMM, OP, LUI and AUIPC.
// Revision : 1.0 - initial release
// ============================================================================
module id_decoder
    import id_pkg::*;
(
    input  logic [31:0] i_inst,
    output dec_t        o_dec
);

    logic [6:0] w_opcode;
    logic [2:0] w_f3;
    logic       w_f7_zero;
    logic       w_f7_alt;
    logic       w_ill;

    assign w_opcode  = i_inst[6:0];
    assign w_f3      = i_inst[14:12];
    assign w_f7_zero = (i_inst[31:25] == 7'b0000000);
    assign w_f7_alt  = (i_inst[31:25] == 7'b0100000);

    always_comb begin
        w_ill           = 1'b0;
        o_dec.aluop     = f_f3_aluop(w_f3);
        o_dec.alusel    = SEL_NOP;
        o_dec.op1_sel   = OP1_RS1;
        o_dec.use_rs2   = 1'b0;
        o_dec.imm       = {{20{i_inst[31]}}, i_inst[31:20]};
        o_dec.rs1       = i_inst[19:15];
        o_dec.rs2       = i_inst[24:20];
        o_dec.wd        = i_inst[11:7];
        o_dec.wreg      = 1'b1;
        o_dec.illegal   = 1'b0;

        case (w_opcode)
            c_OPC_LUI, c_OPC_AUIPC: begin
                o_dec.aluop   = ALU_ADD;
                o_dec.op1_sel = (w_opcode == c_OPC_LUI) ? OP1_ZERO : OP1_PC;
                o_dec.imm     = {i_inst[31:12], 12'b0};
            end
            c_OPC_OP_IMM: begin
                // funct7 only exists for the shift immediates; elsewhere it is imm bits
                if (w_f3 == c_F3_SLL || w_f3 == c_F3_SR) begin
                    o_dec.imm = {27'b0, i_inst[24:20]};
                    w_ill     = !(w_f7_zero || (w_f7_alt && w_f3 == c_F3_SR));
                end
                if (w_f7_alt && w_f3 == c_F3_SR) begin
                    o_dec.aluop = ALU_SRA;
                end
            end
            c_OPC_OP: begin
                o_dec.use_rs2 = 1'b1;
                w_ill = !(w_f7_zero || (w_f7_alt && (w_f3 == c_F3_ADD || w_f3 == c_F3_SR)));
                if (w_f7_alt) begin
                    o_dec.aluop = (w_f3 == c_F3_ADD) ? ALU_SUB : ALU_SRA;
                end
            end
            default: w_ill = 1'b1;
        endcase

        if (w_ill) begin
            o_dec.aluop   = ALU_NOP;
            o_dec.op1_sel = OP1_ZERO;
            o_dec.use_rs2 = 1'b0;
            o_dec.imm     = 32'd0;
            o_dec.wreg    = 1'b0;
            o_dec.illegal = 1'b1;
        end
        if (o_dec.wd == 5'd0) begin
            o_dec.wreg = 1'b0;
        end
        o_dec.alusel = f_alusel(o_dec.aluop);
    end

endmodule
`default_nettype wire

// File: rtl/id_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_stage
// Purpose  : RV32I decode with N-source forwarding, load-use interlock and
//            ID/EX register under valid/ready with flush.
// Revision : 1.0 - initial release
// ============================================================================
module id_stage
    import id_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int NUM_FWD = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      id_valid,
    output logic                      id_ready,
    input  logic [XLEN-1:0]           pc_i,
    input  logic [31:0]               inst_i,
    output logic [4:0]                rs1_addr_o,
    output logic [4:0]                rs2_addr_o,
    input  logic [XLEN-1:0]           rs1_data_i,
    input  logic [XLEN-1:0]           rs2_data_i,
    input  logic [NUM_FWD-1:0]        fwd_wreg_i,
    input  logic [5*NUM_FWD-1:0]      fwd_wd_i,
    input  logic [XLEN*NUM_FWD-1:0]   fwd_wdata_i,
    input  logic [NUM_FWD-1:0]        fwd_is_load_i,
    input  logic                      flush_i,
    output logic                      ex_valid_o,
    input  logic                      ex_ready_i,
    output logic [ALUOP_W-1:0]        aluop_o,
    output logic [ALUSEL_W-1:0]       alusel_o,
    output logic [XLEN-1:0]           op1_o,
    output logic [XLEN-1:0]           op2_o,
    output logic [4:0]                wd_o,
    output logic                      wreg_o,
    output logic                      illegal_o
);

    dec_t            w_dec;
    logic [XLEN:0]   w_rs1_fwd;
    logic [XLEN:0]   w_rs2_fwd;
    logic [XLEN-1:0] w_imm;
    logic [XLEN-1:0] w_op1;
    logic [XLEN-1:0] w_op2;
    logic            w_stall;
    logic            w_adv;

    logic            r_ex_valid;
    aluop_e          r_aluop;
    alusel_e         r_alusel;
    logic [XLEN-1:0] r_op1;
    logic [XLEN-1:0] r_op2;
    logic [4:0]      r_wd;
    logic            r_wreg;
    logic            r_illegal;

    id_decoder u_decoder (
        .i_inst (inst_i),
        .o_dec  (w_dec)
    );

    assign rs1_addr_o = w_dec.rs1;
    assign rs2_addr_o = w_dec.rs2;

    // Returns {load_pending, value}; walking from oldest to youngest lets index 0 win.
    function automatic logic [XLEN:0] f_fwd(
        input logic [4:0]              a,
        input logic [XLEN-1:0]         rf,
        input logic [NUM_FWD-1:0]      we,
        input logic [5*NUM_FWD-1:0]    wd,
        input logic [XLEN*NUM_FWD-1:0] wdat,
        input logic [NUM_FWD-1:0]      ld
    );
        logic [XLEN:0] r;
        r = {1'b0, rf};
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (we[i] && (wd[5*i +: 5] == a)) begin
                r = {ld[i], wdat[XLEN*i +: XLEN]};
            end
        end
        if (a == 5'd0) begin
            r = '0;
        end
        return r;
    endfunction

    assign w_rs1_fwd = f_fwd(w_dec.rs1, rs1_data_i, fwd_wreg_i, fwd_wd_i, fwd_wdata_i, fwd_is_load_i);
    assign w_rs2_fwd = f_fwd(w_dec.rs2, rs2_data_i, fwd_wreg_i, fwd_wd_i, fwd_wdata_i, fwd_is_load_i);

    assign w_stall = ((w_dec.op1_sel == OP1_RS1) && w_rs1_fwd[XLEN])
                   || (w_dec.use_rs2 && w_rs2_fwd[XLEN]);
    assign w_adv   = !r_ex_valid || ex_ready_i;
    assign id_ready = w_adv && !w_stall;

    assign w_imm = XLEN'($signed(w_dec.imm));

    always_comb begin
        w_op1 = '0;
        case (w_dec.op1_sel)
            OP1_PC:  w_op1 = pc_i;
            OP1_RS1: w_op1 = w_rs1_fwd[XLEN-1:0];
            default: w_op1 = '0;
        endcase
    end

    assign w_op2 = w_dec.use_rs2 ? w_rs2_fwd[XLEN-1:0] : w_imm;

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            r_ex_valid <= 1'b0;
            r_aluop    <= ALU_NOP;
            r_alusel   <= SEL_NOP;
            r_op1      <= '0;
            r_op2      <= '0;
            r_wd       <= 5'd0;
            r_wreg     <= 1'b0;
            r_illegal  <= 1'b0;
        end else if (w_adv) begin
            r_ex_valid <= id_valid && !w_stall;
            r_aluop    <= w_dec.aluop;
            r_alusel   <= w_dec.alusel;
            r_op1      <= w_op1;
            r_op2      <= w_op2;
            r_wd       <= w_dec.wd;
            r_wreg     <= w_dec.wreg;
            r_illegal  <= w_dec.illegal;
        end
    end

    assign ex_valid_o = r_ex_valid;
    assign aluop_o    = r_aluop;
    assign alusel_o   = r_alusel;
    assign op1_o      = r_op1;
    assign op2_o      = r_op2;
    assign wd_o       = r_wd;
    assign wreg_o     = r_wreg;
    assign illegal_o  = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_id_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_stage
// Purpose  : Directed self-checking bench for id_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_stage;

    localparam int XLEN    = 32;
    localparam int NUM_FWD = 2;

    localparam logic [3:0] c_NOP = 4'd0;
    localparam logic [3:0] c_ADD = 4'd1;
    localparam logic [3:0] c_SUB = 4'd2;
    localparam logic [3:0] c_AND = 4'd7;
    localparam logic [3:0] c_SRA = 4'd10;
    localparam logic [1:0] c_SEL_NOP   = 2'd0;
    localparam logic [1:0] c_SEL_LOGIC = 2'd1;
    localparam logic [1:0] c_SEL_SHIFT = 2'd2;
    localparam logic [1:0] c_SEL_MATH  = 2'd3;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    id_valid;
    logic                    id_ready;
    logic [XLEN-1:0]         pc_i;
    logic [31:0]             inst_i;
    logic [4:0]              rs1_addr_o;
    logic [4:0]              rs2_addr_o;
    logic [XLEN-1:0]         rs1_data_i;
    logic [XLEN-1:0]         rs2_data_i;
    logic [NUM_FWD-1:0]      fwd_wreg_i;
    logic [5*NUM_FWD-1:0]    fwd_wd_i;
    logic [XLEN*NUM_FWD-1:0] fwd_wdata_i;
    logic [NUM_FWD-1:0]      fwd_is_load_i;
    logic                    flush_i;
    logic                    ex_valid_o;
    logic                    ex_ready_i;
    logic [3:0]              aluop_o;
    logic [1:0]              alusel_o;
    logic [XLEN-1:0]         op1_o;
    logic [XLEN-1:0]         op2_o;
    logic [4:0]              wd_o;
    logic                    wreg_o;
    logic                    illegal_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    id_stage #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) dut (
        .clk           (clk),
        .rst           (rst),
        .id_valid      (id_valid),
        .id_ready      (id_ready),
        .pc_i          (pc_i),
        .inst_i        (inst_i),
        .rs1_addr_o    (rs1_addr_o),
        .rs2_addr_o    (rs2_addr_o),
        .rs1_data_i    (rs1_data_i),
        .rs2_data_i    (rs2_data_i),
        .fwd_wreg_i    (fwd_wreg_i),
        .fwd_wd_i      (fwd_wd_i),
        .fwd_wdata_i   (fwd_wdata_i),
        .fwd_is_load_i (fwd_is_load_i),
        .flush_i       (flush_i),
        .ex_valid_o    (ex_valid_o),
        .ex_ready_i    (ex_ready_i),
        .aluop_o       (aluop_o),
        .alusel_o      (alusel_o),
        .op1_o         (op1_o),
        .op2_o         (op2_o),
        .wd_o          (wd_o),
        .wreg_o        (wreg_o),
        .illegal_o     (illegal_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic chk_ex(input string tag, input logic v, input logic [3:0] op, input logic [1:0] sel,
                          input logic [31:0] a, input logic [31:0] b, input logic [4:0] wd,
                          input logic wr, input logic ill);
        check({tag, ".valid"},   ex_valid_o, v);
        check({tag, ".aluop"},   aluop_o,    op);
        check({tag, ".alusel"},  alusel_o,   sel);
        check({tag, ".op1"},     op1_o,      a);
        check({tag, ".op2"},     op2_o,      b);
        check({tag, ".wd"},      wd_o,       wd);
        check({tag, ".wreg"},    wreg_o,     wr);
        check({tag, ".illegal"}, illegal_o,  ill);
    endtask

    task automatic chk_ill(input string tag);
        check({tag, ".valid"},   ex_valid_o, 1'b1);
        check({tag, ".illegal"}, illegal_o,  1'b1);
        check({tag, ".wreg"},    wreg_o,     1'b0);
        check({tag, ".aluop"},   aluop_o,    c_NOP);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fwd(input logic [1:0] we, input logic [4:0] wd0, input logic [4:0] wd1,
                           input logic [31:0] d0, input logic [31:0] d1, input logic [1:0] ld);
        fwd_wreg_i    = we;
        fwd_wd_i      = {wd1, wd0};
        fwd_wdata_i   = {d1, d0};
        fwd_is_load_i = ld;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; id_valid = 1'b0; pc_i = '0; inst_i = 32'h0000_0013;
        rs1_data_i = '0; rs2_data_i = '0; flush_i = 1'b0; ex_ready_i = 1'b1;
        set_fwd(2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 2'b00);
        tick();
        tick();
        chk_ex("reset", 1'b0, c_NOP, c_SEL_NOP, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
        rst = 1'b0;

        // ADDI x1,x0,-1: x0 read yields zero even with non-zero regfile data
        id_valid = 1'b1; inst_i = 32'hFFF0_0093; rs1_data_i = 32'hDEAD_BEEF;
        #1;
        check("addi.id_ready", id_ready, 1'b1);
        check("addi.rs1_addr", rs1_addr_o, 5'd0);
        tick();
        chk_ex("addi", 1'b1, c_ADD, c_SEL_MATH, 32'd0, 32'hFFFF_FFFF, 5'd1, 1'b1, 1'b0);

        // ADD x3,x1,x2: youngest source wins for x1
        inst_i = 32'h0020_81B3; rs1_data_i = 32'h0000_AAAA; rs2_data_i = 32'h0000_BBBB;
        set_fwd(2'b11, 5'd1, 5'd1, 32'd5, 32'd9, 2'b00);
        #1;
        check("add.rs2_addr", rs2_addr_o, 5'd2);
        tick();
        chk_ex("add_young", 1'b1, c_ADD, c_SEL_MATH, 32'd5, 32'h0000_BBBB, 5'd3, 1'b1, 1'b0);
        set_fwd(2'b11, 5'd1, 5'd2, 32'd5, 32'd7, 2'b00);
        tick();
        check("add_old.op1", op1_o, 32'd5);
        check("add_old.op2", op2_o, 32'd7);

        // ADD x3,x0,x2 with a source claiming x0: must still read zero
        inst_i = 32'h0020_01B3;
        set_fwd(2'b01, 5'd0, 5'd0, 32'd99, 32'd0, 2'b00);
        tick();
        check("x0fwd.op1", op1_o, 32'd0);
        check("x0fwd.op2", op2_o, 32'h0000_BBBB);

        // Load-use: LW x1 in EX, then ADDI x4,x1,1
        inst_i = 32'h0010_8213;
        set_fwd(2'b01, 5'd1, 5'd0, 32'h77, 32'd0, 2'b01);
        #1;
        check("lduse.id_ready", id_ready, 1'b0);
        tick();
        check("lduse.bubble", ex_valid_o, 1'b0);
        set_fwd(2'b10, 5'd0, 5'd1, 32'd0, 32'h10, 2'b00);
        #1;
        check("lduse.resume", id_ready, 1'b1);
        tick();
        chk_ex("lduse", 1'b1, c_ADD, c_SEL_MATH, 32'h10, 32'd1, 5'd4, 1'b1, 1'b0);

        // Backpressure: SUB x7,x1,x2 held for 3 cycles, stall during hold gives no bubble
        set_fwd(2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 2'b00);
        inst_i = 32'h4020_83B3; rs1_data_i = 32'h50; rs2_data_i = 32'h20;
        tick();
        chk_ex("sub", 1'b1, c_SUB, c_SEL_MATH, 32'h50, 32'h20, 5'd7, 1'b1, 1'b0);
        ex_ready_i = 1'b0; inst_i = 32'hFF01_7413; rs1_data_i = 32'h1234;
        #1;
        check("hold.id_ready", id_ready, 1'b0);
        for (int k = 0; k < 3; k++) begin
            if (k == 1) set_fwd(2'b01, 5'd2, 5'd0, 32'd0, 32'd0, 2'b01);
            tick();
            chk_ex("hold", 1'b1, c_SUB, c_SEL_MATH, 32'h50, 32'h20, 5'd7, 1'b1, 1'b0);
            check("hold.id_ready", id_ready, 1'b0);
        end
        set_fwd(2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 2'b00);
        flush_i = 1'b1;
        tick();
        check("flush.valid", ex_valid_o, 1'b0);
        check("flush.wreg", wreg_o, 1'b0);
        flush_i = 1'b0; ex_ready_i = 1'b1;
        #1;
        check("flush.id_ready", id_ready, 1'b1);
        tick();
        chk_ex("andi", 1'b1, c_AND, c_SEL_LOGIC, 32'h1234, 32'hFFFF_FFF0, 5'd8, 1'b1, 1'b0);

        // SRAI x6,x1,3: shamt zero-extended
        inst_i = 32'h4030_D313; rs1_data_i = 32'h8000_0000;
        tick();
        chk_ex("srai", 1'b1, c_SRA, c_SEL_SHIFT, 32'h8000_0000, 32'd3, 5'd6, 1'b1, 1'b0);

        // Illegal encodings
        inst_i = 32'h0220_81B3;
        tick();
        chk_ill("ill_f7");
        inst_i = 32'h0000_007F;
        tick();
        chk_ill("ill_opc");
        inst_i = 32'h4000_9093;
        tick();
        chk_ill("ill_slli");

        // LUI x0 and AUIPC x5,1
        inst_i = 32'h1234_5037;
        tick();
        chk_ex("lui_x0", 1'b1, c_ADD, c_SEL_MATH, 32'd0, 32'h1234_5000, 5'd0, 1'b0, 1'b0);
        inst_i = 32'h0000_1297; pc_i = 32'h100;
        tick();
        chk_ex("auipc", 1'b1, c_ADD, c_SEL_MATH, 32'h100, 32'h1000, 5'd5, 1'b1, 1'b0);

        id_valid = 1'b0;
        tick();
        check("idle.valid", ex_valid_o, 1'b0);

        // Reset in the middle of a valid stream
        id_valid = 1'b1;
        tick();
        check("prerst.valid", ex_valid_o, 1'b1);
        rst = 1'b1;
        tick();
        chk_ex("midrst", 1'b0, c_NOP, c_SEL_NOP, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
        rst = 1'b0; id_valid = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
